// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the byte-serial instruction loader.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StRun
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/inst_loader_sync_edge.sv
// Two-flop synchronizer for a pad-level input, with rise/fall pulses on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/inst_loader.sv
// Assembles pad bytes into little-endian words, writes them to instruction memory and
// holds the CPU in reset until loading finishes.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              byte_strb,
    input  logic [7:0]        byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(2 ** ADDR_W);

    logic w_load_lvl, w_load_rise, w_load_fall;
    logic w_strb_lvl, w_strb_rise, w_strb_fall;
    logic w_unused;

    sync_edge u_sync_load (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (load_en),
        .o_level (w_load_lvl),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    sync_edge u_sync_strb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (byte_strb),
        .o_level (w_strb_lvl),
        .o_rise  (w_strb_rise),
        .o_fall  (w_strb_fall)
    );

    assign w_unused = ^{w_load_fall, w_strb_lvl, w_strb_fall};

    state_e              r_state, w_state_d;
    logic [LANE_W-1:0]   r_idx, w_idx_d;
    logic [WORD_W-1:0]   r_asm, w_asm_d, w_asm_new;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_d;
    logic [ADDR_W:0]     r_word_count, w_cnt_d;
    logic                r_overflow, w_ovf_d;
    logic                r_mem_we, w_we_d;
    logic [ADDR_W-1:0]   r_mem_addr, w_addr_d;
    logic [WORD_W-1:0]   r_mem_wdata, w_wdata_d;
    logic                r_cpu_rst_n, r_busy, r_done;
    logic                w_full;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_asm_d   = r_asm;
        w_asm_new = r_asm;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_word_count;
        w_ovf_d   = r_overflow;
        w_we_d    = 1'b0;
        w_addr_d  = r_mem_addr;
        w_wdata_d = r_mem_wdata;
        w_full    = (r_word_count == FullCnt);

        // Counters advance the edge after the write pulse; the pointer saturates.
        if (r_mem_we) begin
            w_cnt_d = r_word_count + (ADDR_W + 1)'(1);
            if (r_ptr != {ADDR_W{1'b1}}) begin
                w_ptr_d = r_ptr + ADDR_W'(1);
            end
        end

        unique case (r_idx)
            2'd0: w_asm_new[7:0]   = byte_in;
            2'd1: w_asm_new[15:8]  = byte_in;
            2'd2: w_asm_new[23:16] = byte_in;
            2'd3: w_asm_new[31:24] = byte_in;
        endcase

        unique case (r_state)
            StLoad: begin
                if (w_strb_rise) begin
                    if (w_full) begin
                        w_ovf_d = 1'b1;
                    end else if (r_idx == LANE_W'(BYTES_PER_WORD - 1)) begin
                        w_we_d    = 1'b1;
                        w_addr_d  = r_ptr;
                        w_wdata_d = w_asm_new;
                        w_asm_d   = '0;
                        w_idx_d   = '0;
                    end else begin
                        w_asm_d = w_asm_new;
                        w_idx_d = r_idx + LANE_W'(1);
                    end
                end
                // A byte arriving with the load_en fall is already folded into w_asm_d.
                if (!w_load_lvl) begin
                    if (w_idx_d != '0) begin
                        w_state_d = StFlush;
                        if (!w_full) begin
                            w_we_d    = 1'b1;
                            w_addr_d  = r_ptr;
                            w_wdata_d = w_asm_d;
                        end
                        w_asm_d = '0;
                        w_idx_d = '0;
                    end else begin
                        w_state_d = StRun;
                    end
                end
            end
            StFlush: w_state_d = StRun;
            StIdle, StRun: begin
            end
        endcase

        if (w_load_rise) begin
            w_state_d = StLoad;
            w_idx_d   = '0;
            w_asm_d   = '0;
            w_ptr_d   = '0;
            w_cnt_d   = '0;
            w_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_asm        <= '0;
            r_ptr        <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_asm        <= w_asm_d;
            r_ptr        <= w_ptr_d;
            r_word_count <= w_cnt_d;
            r_overflow   <= w_ovf_d;
            r_mem_we     <= w_we_d;
            r_mem_addr   <= w_addr_d;
            r_mem_wdata  <= w_wdata_d;
            r_cpu_rst_n  <= (w_state_d == StRun);
            r_busy       <= (w_state_d == StLoad) || (w_state_d == StFlush);
            r_done       <= (w_state_d == StRun);
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign word_count = r_word_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
